// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control.
package pipeline_ctrl_pkg;

  // EX operand select codes; 2'b11 is reserved and never produced.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  // Shadow entries hold indices zero-extended to this width, so a compare
  // at this width gives the same result as one at the instance's own width.
  localparam int REG_ADDR_W_MAX = 8;

  // Legal values of LOAD_LAT: data ready at end of MEM, or only at WB.
  localparam int LOAD_LAT_MEM = 1;
  localparam int LOAD_LAT_WB  = 2;

  // Legal values of BR_STAGE: branches resolve in EX or in MEM.
  localparam int BR_STAGE_EX  = 0;
  localparam int BR_STAGE_MEM = 1;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_MAX-1:0] rd;
    logic [REG_ADDR_W_MAX-1:0] rs1;
    logic [REG_ADDR_W_MAX-1:0] rs2;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      reg_write;
    logic                      mem_read;
  } stage_entry_t;

  // Youngest usable producer wins: MEM before WB.
  function automatic fwd_sel_t fwd_encode(input logic mem_hit,
                                          input logic mem_fwd_ok,
                                          input logic wb_hit);
    if (mem_hit && mem_fwd_ok) return FWD_MEM;
    if (wb_hit)                return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-side request signals and hazard/forward control outputs.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5
);
  import pipeline_ctrl_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  branch_taken;

  logic                  pc_hold;
  logic                  if_id_hold;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  ex_mem_flush;
  fwd_sel_t              fwd_a;
  fwd_sel_t              fwd_b;
  logic                  id_bypass1;
  logic                  id_bypass2;

  // Pipeline side: presents the ID instruction, consumes the controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, branch_taken,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush,
           fwd_a, fwd_b, id_bypass1, id_bypass2
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, branch_taken,
    output pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush,
           fwd_a, fwd_b, id_bypass1, id_bypass2
  );

endinterface

// File: rtl/hazard_forward_unit_reg_match.sv
// Producer match: a live register-writing stage whose non-x0 destination
// equals a source index that the consumer actually reads.
module reg_match #(
  parameter int W = 5
) (
  input  logic         prod_valid,
  input  logic         prod_reg_write,
  input  logic [W-1:0] prod_rd,
  input  logic [W-1:0] src,
  input  logic         src_used,
  output logic         hit
);

  assign hit = prod_valid && prod_reg_write && (prod_rd != '0) &&
               (prod_rd == src) && src_used;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 5-stage core: shadow
// EX/MEM/WB destination info, load-use stalls, branch flushes, EX operand
// forward selects and WB->ID write-through.
module hazard_forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = LOAD_LAT_MEM,
  parameter int BR_STAGE   = BR_STAGE_MEM
) (
  input  logic                CLK,
  input  logic                RESET_N,
  hazard_forward_unit_if.slave hif
);

  // Match slots: forwarding (EX sources), stall (ID vs EX/MEM), bypass (ID vs WB).
  localparam int M_MEM_A  = 0;
  localparam int M_MEM_B  = 1;
  localparam int M_WB_A   = 2;
  localparam int M_WB_B   = 3;
  localparam int M_EX_ID1 = 4;
  localparam int M_EX_ID2 = 5;
  localparam int M_MEM_ID1 = 6;
  localparam int M_MEM_ID2 = 7;
  localparam int M_WB_ID1 = 8;
  localparam int M_WB_ID2 = 9;
  localparam int N_MATCH  = 10;

  stage_entry_t ex_q, mem_q, wb_q;
  stage_entry_t id_entry, ex_next, mem_next;

  stage_entry_t              m_prod [N_MATCH];
  logic [REG_ADDR_W_MAX-1:0] m_src  [N_MATCH];
  logic                      m_use  [N_MATCH];
  logic [N_MATCH-1:0]        hit;

  logic stall;
  logic flush;
  logic mem_fwd_ok;

  // Pack the ID instruction into a shadow entry.
  always_comb begin
    id_entry           = '0;
    id_entry.valid     = hif.id_valid;
    id_entry.rd        = REG_ADDR_W_MAX'(hif.id_rd);
    id_entry.rs1       = REG_ADDR_W_MAX'(hif.id_rs1);
    id_entry.rs2       = REG_ADDR_W_MAX'(hif.id_rs2);
    id_entry.uses_rs1  = hif.id_uses_rs1;
    id_entry.uses_rs2  = hif.id_uses_rs2;
    id_entry.reg_write = hif.id_reg_write;
    id_entry.mem_read  = hif.id_mem_read;
  end

  // Route producer/source pairs to the match comparators.
  always_comb begin
    m_prod[M_MEM_A]   = mem_q; m_src[M_MEM_A]   = ex_q.rs1; m_use[M_MEM_A]   = ex_q.valid && ex_q.uses_rs1;
    m_prod[M_MEM_B]   = mem_q; m_src[M_MEM_B]   = ex_q.rs2; m_use[M_MEM_B]   = ex_q.valid && ex_q.uses_rs2;
    m_prod[M_WB_A]    = wb_q;  m_src[M_WB_A]    = ex_q.rs1; m_use[M_WB_A]    = ex_q.valid && ex_q.uses_rs1;
    m_prod[M_WB_B]    = wb_q;  m_src[M_WB_B]    = ex_q.rs2; m_use[M_WB_B]    = ex_q.valid && ex_q.uses_rs2;
    m_prod[M_EX_ID1]  = ex_q;  m_src[M_EX_ID1]  = id_entry.rs1; m_use[M_EX_ID1]  = id_entry.uses_rs1;
    m_prod[M_EX_ID2]  = ex_q;  m_src[M_EX_ID2]  = id_entry.rs2; m_use[M_EX_ID2]  = id_entry.uses_rs2;
    m_prod[M_MEM_ID1] = mem_q; m_src[M_MEM_ID1] = id_entry.rs1; m_use[M_MEM_ID1] = id_entry.uses_rs1;
    m_prod[M_MEM_ID2] = mem_q; m_src[M_MEM_ID2] = id_entry.rs2; m_use[M_MEM_ID2] = id_entry.uses_rs2;
    m_prod[M_WB_ID1]  = wb_q;  m_src[M_WB_ID1]  = id_entry.rs1; m_use[M_WB_ID1]  = id_entry.uses_rs1;
    m_prod[M_WB_ID2]  = wb_q;  m_src[M_WB_ID2]  = id_entry.rs2; m_use[M_WB_ID2]  = id_entry.uses_rs2;
  end

  for (genvar g = 0; g < N_MATCH; g++) begin : g_match
    reg_match #(.W(REG_ADDR_W_MAX)) u_match (
      .prod_valid     (m_prod[g].valid),
      .prod_reg_write (m_prod[g].reg_write),
      .prod_rd        (m_prod[g].rd),
      .src            (m_src[g]),
      .src_used       (m_use[g]),
      .hit            (hit[g])
    );
  end

  // Stall/flush decision, control outputs and forward selects.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block
    // leaves a signal unassigned, which would infer a latch.
    hif.pc_hold      = 1'b0;
    hif.if_id_hold   = 1'b0;
    hif.if_id_flush  = 1'b0;
    hif.id_ex_bubble = 1'b0;
    hif.ex_mem_flush = 1'b0;

    stall = hif.id_valid &&
            ((ex_q.mem_read && (hit[M_EX_ID1] || hit[M_EX_ID2])) ||
             ((LOAD_LAT == LOAD_LAT_WB) && mem_q.mem_read &&
              (hit[M_MEM_ID1] || hit[M_MEM_ID2])));
    flush = hif.branch_taken;

    if (flush) begin
      // A taken branch discards the stalled instruction, so no hold.
      hif.if_id_flush  = 1'b1;
      hif.id_ex_bubble = 1'b1;
      hif.ex_mem_flush = (BR_STAGE == BR_STAGE_MEM);
    end else if (stall) begin
      hif.pc_hold      = 1'b1;
      hif.if_id_hold   = 1'b1;
      hif.id_ex_bubble = 1'b1;
    end

    // A load in MEM has no data yet when it only arrives at WB.
    mem_fwd_ok = !((LOAD_LAT == LOAD_LAT_WB) && mem_q.mem_read);
    hif.fwd_a  = fwd_encode(hit[M_MEM_A], mem_fwd_ok, hit[M_WB_A]);
    hif.fwd_b  = fwd_encode(hit[M_MEM_B], mem_fwd_ok, hit[M_WB_B]);

    hif.id_bypass1 = hit[M_WB_ID1];
    hif.id_bypass2 = hit[M_WB_ID2];
  end

  // Next shadow contents: bubbles enter EX on stall/flush, a MEM-resolved
  // branch also kills the wrong-path instruction leaving EX.
  always_comb begin
    ex_next  = id_entry;
    mem_next = ex_q;
    if (flush || stall) ex_next.valid = 1'b0;
    if (flush && (BR_STAGE == BR_STAGE_MEM)) mem_next.valid = 1'b0;
  end

  // Shadow pipeline register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      // NOTE: only the valid bits are reset; payload fields are ignored
      // while valid is low, so they need no reset.
      ex_q.valid  <= 1'b0;
      mem_q.valid <= 1'b0;
      wb_q.valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all three stages shift from the
      // values held before this edge.
      ex_q  <= ex_next;
      mem_q <= mem_next;
      wb_q  <= mem_q;
    end
  end

  // The WB entry only needs producer fields.
  logic unused_wb;
  assign unused_wb = ^{wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2, wb_q.mem_read};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: two configurations
// (LOAD_LAT=1/BR_STAGE=0 and LOAD_LAT=2/BR_STAGE=1), instruction streams
// driven into ID, hand-derived expected controls compared each cycle.
module tb_hazard_forward_unit;

  logic CLK;
  logic RESET_N;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_forward_unit_if #(.REG_ADDR_W(5)) if1 ();
  hazard_forward_unit_if #(.REG_ADDR_W(5)) if2 ();

  hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .BR_STAGE(0)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .hif(if1)
  );
  hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LAT(2), .BR_STAGE(1)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .hif(if2)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic       ph;
    logic       ih;
    logic       fl;
    logic       bub;
    logic       emf;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       b1;
    logic       b2;
  } obs_t;

  typedef struct {
    int    sel;
    obs_t  exp;
    string tag;
  } sb_t;

  sb_t  sb_q[$];
  obs_t obs1, obs2;
  int   checks = 0;
  int   errors = 0;

  assign obs1 = {if1.pc_hold, if1.if_id_hold, if1.if_id_flush, if1.id_ex_bubble,
                 if1.ex_mem_flush, if1.fwd_a, if1.fwd_b, if1.id_bypass1, if1.id_bypass2};
  assign obs2 = {if2.pc_hold, if2.if_id_hold, if2.if_id_flush, if2.id_ex_bubble,
                 if2.ex_mem_flush, if2.fwd_a, if2.fwd_b, if2.id_bypass1, if2.id_bypass2};

  localparam obs_t O_IDLE  = '0;
  localparam obs_t O_STALL = '{ph: 1'b1, ih: 1'b1, fl: 1'b0, bub: 1'b1, emf: 1'b0,
                               fa: 2'b00, fb: 2'b00, b1: 1'b0, b2: 1'b0};

  function automatic obs_t mk(logic ph, logic ih, logic fl, logic bub, logic emf,
                              logic [1:0] fa, logic [1:0] fb, logic b1, logic b2);
    obs_t o;
    o = '{ph: ph, ih: ih, fl: fl, bub: bub, emf: emf, fa: fa, fb: fb, b1: b1, b2: b2};
    return o;
  endfunction

  function automatic instr_t alu(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
    instr_t i;
    i = '{valid: 1'b1, rd: rd, rs1: a, rs2: b, u1: 1'b1, u2: 1'b1, rw: 1'b1, mr: 1'b0};
    return i;
  endfunction

  function automatic instr_t ld(logic [4:0] rd, logic [4:0] base);
    instr_t i;
    i = '{valid: 1'b1, rd: rd, rs1: base, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rw: 1'b1, mr: 1'b1};
    return i;
  endfunction

  localparam instr_t NOP = '0;

  task automatic check(input string tag, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (ph ih fl bub emf fa fb b1 b2)", tag, act, exp);
    end
  endtask

  // Present an instruction to the selected unit; the other one idles.
  task automatic apply(input int sel, input instr_t ins, input logic br);
    instr_t i1, i2;
    i1 = (sel == 1) ? ins : NOP;
    i2 = (sel == 2) ? ins : NOP;
    if1.id_valid = i1.valid; if1.id_rd = i1.rd; if1.id_rs1 = i1.rs1; if1.id_rs2 = i1.rs2;
    if1.id_uses_rs1 = i1.u1; if1.id_uses_rs2 = i1.u2;
    if1.id_reg_write = i1.rw; if1.id_mem_read = i1.mr;
    if1.branch_taken = (sel == 1) ? br : 1'b0;
    if2.id_valid = i2.valid; if2.id_rd = i2.rd; if2.id_rs1 = i2.rs1; if2.id_rs2 = i2.rs2;
    if2.id_uses_rs1 = i2.u1; if2.id_uses_rs2 = i2.u2;
    if2.id_reg_write = i2.rw; if2.id_mem_read = i2.mr;
    if2.branch_taken = (sel == 2) ? br : 1'b0;
  endtask

  // One cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input int sel, input instr_t ins, input logic br,
                      input logic rst_n, input obs_t exp, input string tag);
    sb_t e;
    @(posedge CLK);
    #1;
    RESET_N = rst_n;
    apply(sel, ins, br);
    sb_q.push_back('{sel: sel, exp: exp, tag: tag});
    @(negedge CLK);
    e = sb_q.pop_front();
    check(e.tag, (e.sel == 1) ? obs1 : obs2, e.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0;
    apply(0, NOP, 1'b0);
    repeat (3) @(posedge CLK);

    step(1, NOP, 1'b0, 1'b1, O_IDLE, "reset_dut1");
    step(2, NOP, 1'b0, 1'b1, O_IDLE, "reset_dut2");

    // ---- LOAD_LAT=1, BR_STAGE=0 ----
    step(1, alu(1, 2, 3),   1'b0, 1'b1, O_IDLE, "t1_add_x1");
    step(1, alu(4, 1, 5),   1'b0, 1'b1, O_IDLE, "t1_add_x4_in_id");
    step(1, NOP,            1'b0, 1'b1, mk(0,0,0,0,0,2'b01,2'b00,0,0), "t1_fwd_mem");
    step(1, alu(1, 2, 3),   1'b0, 1'b1, O_IDLE, "t2_add_x1");
    step(1, alu(8, 9, 10),  1'b0, 1'b1, O_IDLE, "t2_unrelated");
    step(1, alu(6, 7, 1),   1'b0, 1'b1, O_IDLE, "t2_sub_in_id");
    step(1, NOP,            1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b10,0,0), "t2_fwd_wb");
    step(1, alu(1, 2, 3),   1'b0, 1'b1, O_IDLE, "t2b_add_x1");
    step(1, alu(8, 9, 10),  1'b0, 1'b1, O_IDLE, "t2b_unrelated1");
    step(1, alu(11, 12, 13),1'b0, 1'b1, O_IDLE, "t2b_unrelated2");
    step(1, alu(6, 7, 1),   1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,0,1), "t2b_id_bypass2");
    step(1, NOP,            1'b0, 1'b1, O_IDLE, "t2b_fwd_none");
    step(1, ld(5, 0),       1'b0, 1'b1, O_IDLE, "t3_lw_x5");
    step(1, alu(6, 5, 5),   1'b0, 1'b1, O_STALL, "t3_ll1_stall");
    step(1, alu(6, 5, 5),   1'b0, 1'b1, O_IDLE, "t3_ll1_single_bubble");
    step(1, NOP,            1'b0, 1'b1, mk(0,0,0,0,0,2'b10,2'b10,0,0), "t3_ll1_fwd_wb");
    step(1, ld(5, 0),       1'b0, 1'b1, O_IDLE, "t5a_lw_x5");
    step(1, alu(6, 5, 5),   1'b1, 1'b1, mk(0,0,1,1,0,2'b00,2'b00,0,0), "t5a_br0_flush_over_stall");
    step(1, NOP,            1'b0, 1'b1, O_IDLE, "t5a_br0_after_flush");

    // ---- LOAD_LAT=2, BR_STAGE=1 ----
    step(2, ld(5, 0),       1'b0, 1'b1, O_IDLE, "t4_lw_x5");
    step(2, alu(6, 5, 5),   1'b0, 1'b1, O_STALL, "t4_ll2_stall1");
    step(2, alu(6, 5, 5),   1'b0, 1'b1, O_STALL, "t4_ll2_stall2");
    step(2, alu(6, 5, 5),   1'b0, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,1,1), "t4_ll2_bypass");
    step(2, NOP,            1'b0, 1'b1, O_IDLE, "t4_ll2_fwd_none");
    step(2, ld(0, 0),       1'b0, 1'b1, O_IDLE, "t4_lw_x0");
    step(2, alu(6, 0, 0),   1'b0, 1'b1, O_IDLE, "t4_x0_no_stall");
    step(2, NOP,            1'b0, 1'b1, O_IDLE, "t4_x0_no_fwd");
    step(2, ld(5, 0),       1'b0, 1'b1, O_IDLE, "t5_lw_x5");
    step(2, alu(6, 5, 5),   1'b1, 1'b1, mk(0,0,1,1,1,2'b00,2'b00,0,0), "t5_br1_flush_over_stall");
    step(2, alu(7, 5, 5),   1'b0, 1'b1, O_IDLE, "t5_br1_ex_mem_cleared");
    step(2, NOP,            1'b0, 1'b1, O_IDLE, "t5_br1_fwd_none");
    step(2, ld(5, 0),       1'b0, 1'b1, O_IDLE, "t6_lw_x5");
    step(2, alu(6, 5, 5),   1'b0, 1'b1, O_STALL, "t6_stall1");
    step(2, alu(6, 5, 5),   1'b0, 1'b0, O_STALL, "t6_stall_with_reset_low");
    step(2, alu(6, 5, 5),   1'b0, 1'b1, O_IDLE, "t6_no_residual_bubble");
    step(2, NOP,            1'b0, 1'b1, O_IDLE, "t6_fwd_none_after_reset");

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
